seq_trigger_capture: RTL and testbench
======================================

Name: seq_trigger_capture

Overview:
Next-generation logic-capture core with a multi-stage trigger sequencer. Each stage requires a pattern/edge condition to occur a programmable number of times before the next stage is armed. It registers incoming samples and runs pre-fill, armed and post-trigger capture phases. It emits tagged sample packets with a write strobe to the page buffer, and reports the sample numbers of the begin, trigger and end samples.

Parameters:
SAMPLE_WIDTH, 16, probe channel count.
NUM_STAGES, 4, trigger sequencer stages (1..8).
OCC_WIDTH, 16, per-stage occurrence counter width.
SAMPLE_PACKET_WIDTH, 32, packet width; must be >= SAMPLE_WIDTH+4.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high.
sample_data  in  SAMPLE_WIDTH  raw probe inputs.
start  in  1  one-cycle pulse; begins capture when idle.
abort  in  1  one-cycle pulse; terminates capture.
page_full  in  1  downstream cannot accept a packet this cycle.
stages_used  in  3  active stages minus 1 (0 = one stage); clamped to NUM_STAGES-1.
stg_pattern  in  NUM_STAGES*SAMPLE_WIDTH  desired pattern per stage.
stg_care  in  NUM_STAGES*SAMPLE_WIDTH  1 = channel compared.
stg_edge_en  in  NUM_STAGES  stage also requires an edge.
stg_edge_rise  in  NUM_STAGES  1 = rising edge, 0 = falling edge.
stg_edge_ch  in  NUM_STAGES*8  edge channel index.
stg_occ  in  NUM_STAGES*OCC_WIDTH  occurrences required (0 treated as 1).
pre_count  in  32  samples written before arming.
post_count  in  32  samples written after the trigger sample.
idle, pre_trigger, armed, post_trigger  out  1 each  one-hot phase flags.
stage_index  out  3  currently armed stage.
sample_packet  out  SAMPLE_PACKET_WIDTH  {zeros, trig_mark, stage[2:0], sample}.
write_enable  out  1  packet valid.
sample_number  out  32  number of the packet on the bus.
sample_num_begin, sample_num_trig, sample_num_end  out  32 each  captured markers.
overflow  out  1  sticky; a sample was dropped because page_full was high.
done  out  1  one-cycle pulse at capture completion.

Behaviour:
- Input pipeline: latest <= sample_data; previous <= latest. Both reset to 0. A packet for the sample presented at cycle t is registered at t+2.
- Stage match: ((latest ^ pattern) & care) == 0, AND the edge condition if edge_en is set.
  - Rising edge: previous[ch]=0 and latest[ch]=1. Falling edge is the reverse.
  - ch >= SAMPLE_WIDTH never matches an edge.
- Phase FSM: IDLE -> PRE_FILL -> ARMED -> POST -> IDLE. done pulses on the POST -> IDLE transition.
  - IDLE: start moves to PRE_FILL. It clears sample_number, the markers, overflow, stage_index and the occurrence counter.
  - PRE_FILL: when the written count reaches pre_count, move to ARMED. pre_count=0 goes from IDLE straight to ARMED. Matches are ignored in PRE_FILL.
  - ARMED: each cycle the current stage matches, occ increments. When occ+1 >= max(stg_occ,1), stage_index advances and occ clears.
  - Trigger: completing stage stages_used triggers. That sample is written with trig_mark=1, sample_num_trig is latched, and the FSM moves to POST.
  - A stage that completes is not re-evaluated against the same sample for the next stage.
  - POST: after exactly post_count further samples are written, move to IDLE. sample_num_end latches the last written number. post_count=0 ends on the trigger sample.
- Writes: write_enable=1 in PRE_FILL, ARMED and POST while page_full=0.
  - When page_full=1: the sample is dropped, write_enable=0, overflow is set, and sample_number does not advance.
  - Pre/post counts count written samples only.
  - sample_num_begin latches the first written number, which is 0.
  - sample_number is a 32-bit counter that wraps modulo 2^32.
- Abort, any non-idle phase: next cycle goes to IDLE, write_enable=0, done is not pulsed, and the markers hold. Abort wins over a simultaneous trigger or completion.
- Start while not idle is ignored. Simultaneous start+abort in IDLE: abort wins, and the FSM stays in IDLE.
- Reset values:
  - idle=1; all other flags 0.
  - All counters, markers, the packet bus and stage_index are 0.
  - Reset mid-capture returns to IDLE in one cycle without a done pulse.

Decomposition:
- Package seq_capture_pkg holds:
  - phase enum (IDLE, PRE_FILL, ARMED, POST);
  - packet field offsets TRIG_BIT and STAGE_LSB;
  - the edge-type constants.
- One sub-module, trigger_sequencer. It owns previous-sample edge detection, the stage/occurrence counters and the trigger pulse. It has an arm/clear interface.

Test Plan:
- pre=4, post=3, stage0 pattern 0x00A5 with care 0x00FF and occ=1, stimulus 0x00A5 at the 8th sample -> 8 pre/armed writes, trigger packet with trig_mark=1 and sample_num_trig=7, end=10, done pulse.
- Two stages: stage0 rising edge ch3 with occ=3, stage1 pattern 0x8000 -> trigger on the first 0x8000 only after the third ch3 rise; stage_index is 1 in between.
- Match during PRE_FILL (pre=5, match at sample 2) -> no trigger. The first match after arming triggers.
- page_full high for 3 cycles during POST with post=6 -> overflow=1, exactly 6 post writes, and sample_number has no gaps.
- Abort in ARMED -> idle next cycle, write_enable=0, no done pulse. A subsequent start restarts with sample_number 0.
- Reset asserted during POST -> all outputs at reset values next cycle. Edge channel 20 with edge_en=1 -> never triggers.

Source files
------------

// File: rtl/seq_capture_pkg.sv
// seq_capture_pkg: shared constants for the sequenced trigger capture core.
//   - capture phase encoding (IDLE, PRE_FILL, ARMED, POST)
//   - packet field offsets, relative to the top of the sample field
//   - edge-type encoding used by the per-stage edge_rise control
package seq_capture_pkg;

  typedef logic [1:0] phaseT;

  localparam phaseT PH_IDLE     = 2'd0;
  localparam phaseT PH_PRE_FILL = 2'd1;
  localparam phaseT PH_ARMED    = 2'd2;
  localparam phaseT PH_POST     = 2'd3;

  // Packet layout is {zeros, trig_mark, stage[2:0], sample}; offsets are added to SAMPLE_WIDTH.
  localparam int unsigned STAGE_LSB = 0;
  localparam int unsigned TRIG_BIT  = 3;

  localparam logic EDGE_FALL = 1'b0;
  localparam logic EDGE_RISE = 1'b1;

endpackage

// File: rtl/trigger_sequencer.sv
// trigger_sequencer: multi-stage pattern/edge trigger sequencer.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   clear           zero the stage index and occurrence counter
//   arm             evaluate the current stage against 'latest' this cycle
//   latest          newest registered sample; previous sample is kept here for edges
//   stagesUsed      last active stage (clamped to NUM_STAGES-1)
//   stg*            per-stage pattern, care mask, edge controls and occurrence count
//   stageIndex      currently armed stage
//   trigger         combinational: the last stage completes on this sample
module trigger_sequencer
  import seq_capture_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned NUM_STAGES   = 4,
  parameter int unsigned OCC_WIDTH    = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               clear,
  input  logic                               arm,
  input  logic [SAMPLE_WIDTH-1:0]            latest,
  input  logic [2:0]                         stagesUsed,
  input  logic [NUM_STAGES*SAMPLE_WIDTH-1:0] stgPattern,
  input  logic [NUM_STAGES*SAMPLE_WIDTH-1:0] stgCare,
  input  logic [NUM_STAGES-1:0]              stgEdgeEn,
  input  logic [NUM_STAGES-1:0]              stgEdgeRise,
  input  logic [NUM_STAGES*8-1:0]            stgEdgeCh,
  input  logic [NUM_STAGES*OCC_WIDTH-1:0]    stgOcc,
  output logic [2:0]                         stageIndex,
  output logic                               trigger
);

  localparam int unsigned OW1 = OCC_WIDTH + 1;

  logic [SAMPLE_WIDTH-1:0] previous;
  logic [7:0]              matchVec;
  logic [OCC_WIDTH-1:0]    occReq [8];
  logic [2:0]              stageQ, stageD, lastStage;
  logic [OCC_WIDTH-1:0]    occQ, occD;
  logic [OW1-1:0]          occNeed;
  logic                    curMatch, stageDone;

  for (genvar g = 0; g < NUM_STAGES; g++) begin : gStage
    logic [SAMPLE_WIDTH-1:0] pat, care;
    logic [7:0]              ch;
    logic                    edgeHit;

    assign pat       = stgPattern[g*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    assign care      = stgCare[g*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    assign ch        = stgEdgeCh[g*8 +: 8];
    assign occReq[g] = stgOcc[g*OCC_WIDTH +: OCC_WIDTH];

    // Channels at or beyond SAMPLE_WIDTH never hit the loop, so they never match.
    always_comb begin
      edgeHit = 1'b0;
      for (int c = 0; c < SAMPLE_WIDTH; c++) begin
        if (ch == 8'(c)) begin
          edgeHit = (stgEdgeRise[g] == EDGE_RISE) ? (!previous[c] && latest[c])
                                                  : (previous[c] && !latest[c]);
        end
      end
    end

    assign matchVec[g] = (((latest ^ pat) & care) == '0) && (!stgEdgeEn[g] || edgeHit);
  end

  for (genvar g = NUM_STAGES; g < 8; g++) begin : gUnused
    assign matchVec[g] = 1'b0;
    assign occReq[g]   = '0;
  end

  always_comb begin
    lastStage = (stagesUsed > 3'(NUM_STAGES - 1)) ? 3'(NUM_STAGES - 1) : stagesUsed;
    curMatch  = matchVec[stageQ];
    occNeed   = (occReq[stageQ] == '0) ? OW1'(1) : {1'b0, occReq[stageQ]};
    stageDone = ({1'b0, occQ} + 1'b1) >= occNeed;
    trigger   = arm && curMatch && stageDone && (stageQ == lastStage);

    stageD = stageQ;
    occD   = occQ;
    if (clear) begin
      stageD = '0;
      occD   = '0;
    end else if (arm && curMatch) begin
      // Only one stage is evaluated per sample, so a completing stage hands the
      // next sample (not this one) to the following stage.
      if (stageDone) begin
        occD = '0;
        if (stageQ != lastStage) stageD = stageQ + 3'd1;
      end else begin
        occD = occQ + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      previous <= '0;
      stageQ   <= '0;
      occQ     <= '0;
    end else begin
      previous <= latest;
      stageQ   <= stageD;
      occQ     <= occD;
    end
  end

  assign stageIndex = stageQ;

endmodule

// File: rtl/seq_trigger_capture.sv
// seq_trigger_capture: logic-capture core with pre-fill, armed and post-trigger phases.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   sample_data                raw probe inputs (registered, packet appears two cycles later)
//   start, abort               one-cycle controls; abort wins over everything
//   page_full                  downstream stall; the sample of that cycle is dropped
//   stages_used, stg_*         trigger sequencer configuration
//   pre_count, post_count      written samples before arming / after the trigger sample
//   idle..post_trigger         one-hot phase flags
//   stage_index                currently armed stage
//   sample_packet, write_enable, sample_number   packet stream to the page buffer
//   sample_num_begin/trig/end  captured markers
//   overflow                   sticky drop indicator, done  completion pulse
module seq_trigger_capture
  import seq_capture_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH        = 16,
  parameter int unsigned NUM_STAGES          = 4,
  parameter int unsigned OCC_WIDTH           = 16,
  parameter int unsigned SAMPLE_PACKET_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [SAMPLE_WIDTH-1:0]            sample_data,
  input  logic                               start,
  input  logic                               abort,
  input  logic                               page_full,
  input  logic [2:0]                         stages_used,
  input  logic [NUM_STAGES*SAMPLE_WIDTH-1:0] stg_pattern,
  input  logic [NUM_STAGES*SAMPLE_WIDTH-1:0] stg_care,
  input  logic [NUM_STAGES-1:0]              stg_edge_en,
  input  logic [NUM_STAGES-1:0]              stg_edge_rise,
  input  logic [NUM_STAGES*8-1:0]            stg_edge_ch,
  input  logic [NUM_STAGES*OCC_WIDTH-1:0]    stg_occ,
  input  logic [31:0]                        pre_count,
  input  logic [31:0]                        post_count,
  output logic                               idle,
  output logic                               pre_trigger,
  output logic                               armed,
  output logic                               post_trigger,
  output logic [2:0]                         stage_index,
  output logic [SAMPLE_PACKET_WIDTH-1:0]     sample_packet,
  output logic                               write_enable,
  output logic [31:0]                        sample_number,
  output logic [31:0]                        sample_num_begin,
  output logic [31:0]                        sample_num_trig,
  output logic [31:0]                        sample_num_end,
  output logic                               overflow,
  output logic                               done
);

  logic [SAMPLE_WIDTH-1:0]        latest;
  phaseT                          phaseQ, phaseD;
  logic [31:0]                    nextNumQ, nextNumD, numQ, numD, preCntQ, preCntD;
  logic [31:0]                    postCntQ, postCntD, beginQ, beginD, trigNumQ, trigNumD;
  logic [31:0]                    endQ, endD;
  logic                           firstQ, firstD, overflowQ, overflowD, weQ, weD, doneQ, doneD;
  logic [SAMPLE_PACKET_WIDTH-1:0] packetQ, packetD;
  logic                           active, startAct, writeOk, seqArm, trigger;

  always_comb begin
    active   = (phaseQ != PH_IDLE);
    startAct = start && !abort && !active;
    writeOk  = active && !abort && !page_full;
    // Dropped samples are not evaluated, so a trigger sample is always written.
    seqArm   = (phaseQ == PH_ARMED) && writeOk;
  end

  trigger_sequencer #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .NUM_STAGES   (NUM_STAGES),
    .OCC_WIDTH    (OCC_WIDTH)
  ) uSeq (
    .clk         (clk),
    .reset       (reset),
    .clear       (startAct),
    .arm         (seqArm),
    .latest      (latest),
    .stagesUsed  (stages_used),
    .stgPattern  (stg_pattern),
    .stgCare     (stg_care),
    .stgEdgeEn   (stg_edge_en),
    .stgEdgeRise (stg_edge_rise),
    .stgEdgeCh   (stg_edge_ch),
    .stgOcc      (stg_occ),
    .stageIndex  (stage_index),
    .trigger     (trigger)
  );

  always_comb begin
    phaseD    = phaseQ;
    nextNumD  = nextNumQ;
    numD      = numQ;
    preCntD   = preCntQ;
    postCntD  = postCntQ;
    beginD    = beginQ;
    trigNumD  = trigNumQ;
    endD      = endQ;
    firstD    = firstQ;
    overflowD = overflowQ;
    packetD   = packetQ;
    weD       = 1'b0;
    doneD     = 1'b0;

    if (startAct) begin
      phaseD    = (pre_count == '0) ? PH_ARMED : PH_PRE_FILL;
      nextNumD  = '0;
      numD      = '0;
      preCntD   = '0;
      postCntD  = '0;
      beginD    = '0;
      trigNumD  = '0;
      endD      = '0;
      firstD    = 1'b1;
      overflowD = 1'b0;
    end

    if (active && !abort && page_full) overflowD = 1'b1;

    if (writeOk) begin
      weD      = 1'b1;
      numD     = nextNumQ;
      nextNumD = nextNumQ + 32'd1;
      packetD  = '0;
      packetD[SAMPLE_WIDTH-1:0]             = latest;
      packetD[SAMPLE_WIDTH+STAGE_LSB +: 3]  = stage_index;
      packetD[SAMPLE_WIDTH+TRIG_BIT]        = trigger;
      if (firstQ) begin
        beginD = nextNumQ;
        firstD = 1'b0;
      end
      case (phaseQ)
        PH_PRE_FILL: begin
          preCntD = preCntQ + 32'd1;
          if (({1'b0, preCntQ} + 33'd1) >= {1'b0, pre_count}) phaseD = PH_ARMED;
        end
        PH_ARMED: begin
          if (trigger) begin
            trigNumD = nextNumQ;
            if (post_count == '0) begin
              endD   = nextNumQ;
              doneD  = 1'b1;
              phaseD = PH_IDLE;
            end else begin
              phaseD = PH_POST;
            end
          end
        end
        PH_POST: begin
          postCntD = postCntQ + 32'd1;
          if (({1'b0, postCntQ} + 33'd1) >= {1'b0, post_count}) begin
            endD   = nextNumQ;
            doneD  = 1'b1;
            phaseD = PH_IDLE;
          end
        end
        default: ;
      endcase
    end

    if (active && abort) phaseD = PH_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      latest    <= '0;
      phaseQ    <= PH_IDLE;
      nextNumQ  <= '0;
      numQ      <= '0;
      preCntQ   <= '0;
      postCntQ  <= '0;
      beginQ    <= '0;
      trigNumQ  <= '0;
      endQ      <= '0;
      firstQ    <= 1'b0;
      overflowQ <= 1'b0;
      packetQ   <= '0;
      weQ       <= 1'b0;
      doneQ     <= 1'b0;
    end else begin
      latest    <= sample_data;
      phaseQ    <= phaseD;
      nextNumQ  <= nextNumD;
      numQ      <= numD;
      preCntQ   <= preCntD;
      postCntQ  <= postCntD;
      beginQ    <= beginD;
      trigNumQ  <= trigNumD;
      endQ      <= endD;
      firstQ    <= firstD;
      overflowQ <= overflowD;
      packetQ   <= packetD;
      weQ       <= weD;
      doneQ     <= doneD;
    end
  end

  assign idle             = (phaseQ == PH_IDLE);
  assign pre_trigger      = (phaseQ == PH_PRE_FILL);
  assign armed            = (phaseQ == PH_ARMED);
  assign post_trigger     = (phaseQ == PH_POST);
  assign sample_packet    = packetQ;
  assign write_enable     = weQ;
  assign sample_number    = numQ;
  assign sample_num_begin = beginQ;
  assign sample_num_trig  = trigNumQ;
  assign sample_num_end   = endQ;
  assign overflow         = overflowQ;
  assign done             = doneQ;

endmodule

// File: tb/tb_seq_trigger_capture.sv
// Self-checking bench for seq_trigger_capture: a table of single-stage captures
// followed by hand-written multi-cycle sequences.
module tb_seq_trigger_capture;

  localparam int SW = 16;
  localparam int NS = 4;
  localparam int OW = 16;
  localparam int PW = 32;

  logic clk = 1'b0;
  logic reset, start, abort, page_full;
  logic [SW-1:0] sample_data;
  logic [2:0] stages_used;
  logic [NS*SW-1:0] stg_pattern, stg_care;
  logic [NS-1:0] stg_edge_en, stg_edge_rise;
  logic [NS*8-1:0] stg_edge_ch;
  logic [NS*OW-1:0] stg_occ;
  logic [31:0] pre_count, post_count;
  logic idle, pre_trigger, armed, post_trigger, write_enable, overflow, done;
  logic [2:0] stage_index;
  logic [PW-1:0] sample_packet;
  logic [31:0] sample_number, sample_num_begin, sample_num_trig, sample_num_end;

  always #5 clk = ~clk;

  seq_trigger_capture #(
    .SAMPLE_WIDTH(SW), .NUM_STAGES(NS), .OCC_WIDTH(OW), .SAMPLE_PACKET_WIDTH(PW)
  ) dut (
    .clk(clk), .reset(reset), .sample_data(sample_data), .start(start), .abort(abort),
    .page_full(page_full), .stages_used(stages_used), .stg_pattern(stg_pattern),
    .stg_care(stg_care), .stg_edge_en(stg_edge_en), .stg_edge_rise(stg_edge_rise),
    .stg_edge_ch(stg_edge_ch), .stg_occ(stg_occ), .pre_count(pre_count),
    .post_count(post_count), .idle(idle), .pre_trigger(pre_trigger), .armed(armed),
    .post_trigger(post_trigger), .stage_index(stage_index), .sample_packet(sample_packet),
    .write_enable(write_enable), .sample_number(sample_number),
    .sample_num_begin(sample_num_begin), .sample_num_trig(sample_num_trig),
    .sample_num_end(sample_num_end), .overflow(overflow), .done(done)
  );

  int nTests = 0;
  int nFail  = 0;

  // Observations of the packet stream for the current scenario.
  int wrCnt, gapErr, doneCnt, trigAt, trigCnt;
  logic [31:0] prevNum, lastPkt, trigPkt;

  typedef struct {
    int pre;
    int post;
    int matchAt;
    int expWrites;
    int expTrig;
    int expEnd;
  } vecT;

  vecT vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clearObs();
    wrCnt = 0; gapErr = 0; doneCnt = 0; trigAt = -1; trigCnt = 0;
    prevNum = 0; lastPkt = 0; trigPkt = 0;
  endtask

  // Drive one cycle of inputs, then observe the registered outputs on the falling edge.
  task automatic step(input logic [15:0] d, input logic st, input logic ab, input logic pf);
    sample_data = d; start = st; abort = ab; page_full = pf;
    @(negedge clk);
    if (write_enable) begin
      if (sample_number !== ((wrCnt == 0) ? 32'd0 : prevNum + 32'd1)) gapErr++;
      prevNum = sample_number;
      lastPkt = sample_packet;
      if (sample_packet[19]) begin
        trigCnt++;
        trigAt  = int'(sample_number);
        trigPkt = sample_packet;
      end
      wrCnt++;
    end
    if (done) doneCnt++;
  endtask

  task automatic setStage(input int s, input logic [15:0] pat, input logic [15:0] care,
                          input logic en, input logic rise, input logic [7:0] ch,
                          input logic [15:0] occ);
    stg_pattern[s*SW +: SW]  = pat;
    stg_care[s*SW +: SW]     = care;
    stg_edge_en[s]           = en;
    stg_edge_rise[s]         = rise;
    stg_edge_ch[s*8 +: 8]    = ch;
    stg_occ[s*OW +: OW]      = occ;
  endtask

  initial begin
    // pre, post, match sample, expected writes, trigger number, end number
    vecs[0] = '{4, 3, 7, 11, 7, 10};
    vecs[1] = '{0, 0, 0, 1, 0, 0};
    vecs[2] = '{2, 5, 2, 8, 2, 7};
    vecs[3] = '{1, 0, 5, 6, 5, 5};
    vecs[4] = '{3, 2, 3, 6, 3, 5};

    reset = 1'b1; start = 0; abort = 0; page_full = 0; sample_data = '0;
    stages_used = 0; stg_pattern = '0; stg_care = '0; stg_edge_en = '0;
    stg_edge_rise = '0; stg_edge_ch = '0; stg_occ = '0; pre_count = 0; post_count = 0;
    clearObs();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    step(16'h0, 0, 0, 0);

    check("reset_idle", idle, 1);
    check("reset_flags", {pre_trigger, armed, post_trigger, write_enable, overflow, done}, 0);
    check("reset_stage", stage_index, 0);
    check("reset_number", sample_number, 0);
    check("reset_packet", sample_packet, 0);
    check("reset_markers", sample_num_begin | sample_num_trig | sample_num_end, 0);

    // Table: single stage, pattern 0x00A5 on the low byte.
    setStage(0, 16'h00A5, 16'h00FF, 0, 0, 0, 1);
    for (int v = 0; v < 5; v++) begin
      clearObs();
      pre_count = vecs[v].pre; post_count = vecs[v].post;
      for (int k = 0; k < 60 && doneCnt == 0; k++)
        step((k == vecs[v].matchAt) ? 16'h00A5 : 16'h0000, k == 0, 0, 0);
      step(16'h0, 0, 0, 0);
      step(16'h0, 0, 0, 0);
      check($sformatf("v%0d_writes", v), wrCnt, vecs[v].expWrites);
      check($sformatf("v%0d_trig_pkt", v), trigAt, vecs[v].expTrig);
      check($sformatf("v%0d_num_trig", v), sample_num_trig, vecs[v].expTrig);
      check($sformatf("v%0d_num_end", v), sample_num_end, vecs[v].expEnd);
      check($sformatf("v%0d_done_once", v), doneCnt, 1);
      check($sformatf("v%0d_no_gaps", v), gapErr, 0);
    end
    check("v0_trig_data", trigPkt, 32'h0008_00A5);
    check("begin_marker", sample_num_begin, 0);

    // Two stages: third ch3 rise completes stage 0, then 0x8000 triggers.
    begin
      logic [15:0] seqA [8];
      seqA = '{16'h8000, 16'h0008, 16'h0000, 16'h8008, 16'h8000, 16'h0008, 16'h0000,
               16'h8000};
      setStage(0, 16'h0000, 16'h0000, 1, 1, 8'd3, 16'd3);
      setStage(1, 16'h8000, 16'h8000, 0, 0, 0, 1);
      stages_used = 1; pre_count = 0; post_count = 1;
      clearObs();
      for (int k = 0; k < 40 && doneCnt == 0; k++) begin
        step((k < 8) ? seqA[k] : 16'h0000, k == 0, 0, 0);
        if (k == 3) check("two_stage_idx_before", stage_index, 0);
        if (k == 6) check("two_stage_idx_between", stage_index, 1);
      end
      check("two_stage_trig", trigAt, 7);
      check("two_stage_pkt_stage", trigPkt[18:16], 1);
      check("two_stage_end", sample_num_end, 8);
      check("two_stage_writes", wrCnt, 9);
    end

    // Match during pre-fill is ignored.
    stages_used = 0;
    setStage(0, 16'h00A5, 16'h00FF, 0, 0, 0, 1);
    pre_count = 5; post_count = 0;
    clearObs();
    for (int k = 0; k < 40 && doneCnt == 0; k++)
      step((k == 2 || k == 7) ? 16'h00A5 : 16'h0000, k == 0, 0, 0);
    check("prefill_trig", trigAt, 7);
    check("prefill_trig_count", trigCnt, 1);
    check("prefill_writes", wrCnt, 8);

    // page_full for three cycles in POST drops samples 3..5.
    pre_count = 0; post_count = 6;
    clearObs();
    for (int k = 0; k < 40 && doneCnt == 0; k++)
      step((k == 2) ? 16'h00A5 : 16'(k), k == 0, 0, k >= 4 && k <= 6);
    check("pf_overflow", overflow, 1);
    check("pf_writes", wrCnt, 9);
    check("pf_no_gaps", gapErr, 0);
    check("pf_end", sample_num_end, 8);
    check("pf_last_pkt", lastPkt, 32'h0000_000B);

    // Abort in ARMED.
    pre_count = 0; post_count = 0;
    clearObs();
    for (int k = 0; k < 5; k++) step(16'h0000, k == 0, 0, 0);
    check("abort_armed_before", armed, 1);
    step(16'h0000, 0, 1, 0);
    check("abort_idle", idle, 1);
    check("abort_we", write_enable, 0);
    check("abort_num_held", sample_number, 3);
    step(16'h0000, 0, 0, 0);
    check("abort_no_done", doneCnt, 0);
    step(16'h0000, 1, 1, 0);
    check("start_abort_idle", idle, 1);
    clearObs();
    for (int k = 0; k < 20 && doneCnt == 0; k++)
      step((k == 1) ? 16'h00A5 : 16'h0000, k == 0, 0, 0);
    check("restart_trig", trigAt, 1);
    check("restart_no_gaps", gapErr, 0);
    check("restart_writes", wrCnt, 2);

    // Reset during POST.
    pre_count = 0; post_count = 10;
    clearObs();
    for (int k = 0; k < 5; k++) step((k == 1) ? 16'h00A5 : 16'h0000, k == 0, 0, k == 3);
    check("rst_post_before", post_trigger, 1);
    check("rst_overflow_before", overflow, 1);
    reset = 1'b1;
    step(16'h0000, 0, 0, 0);
    reset = 1'b0;
    check("rst_idle", idle, 1);
    check("rst_flags", {pre_trigger, armed, post_trigger, write_enable, overflow, done}, 0);
    check("rst_number", sample_number, 0);
    check("rst_trig_marker", sample_num_trig, 0);
    check("rst_packet", sample_packet, 0);
    clearObs();
    for (int k = 0; k < 3; k++) step(16'h0000, 0, 0, 0);
    check("rst_no_done", doneCnt, 0);

    // Edge channel beyond the sample width never matches.
    setStage(0, 16'h0000, 16'h0000, 1, 1, 8'd20, 1);
    clearObs();
    for (int k = 0; k < 30; k++) step((k % 2 == 1) ? 16'hFFFF : 16'h0000, k == 0, 0, 0);
    check("edge20_no_trig", trigCnt, 0);
    check("edge20_still_armed", armed, 1);
    step(16'h0000, 0, 1, 0);
    check("edge20_abort_idle", idle, 1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
